// File: rtl/i2c_target.sv
`timescale 1ns/1ps
// i2c_target: byte-level I2C target (responder) with a 7-bit address.
//   Detects START/STOP and ACKs its own address. It delivers written bytes to
//   the fabric and returns read bytes supplied by the fabric. It only ever pulls
//   SDA low (sda_oe); the top level owns the actual tristate.
// Optional build macro: I2C_TARGET_GLITCH_FILTER_EN adds a 3-sample stability
//   filter after the synchronizers (+3 cycles latency).
// Ports:
//   ref_clk   in   system clock (48 MHz)
//   rst_n     in   asynchronous active-low reset
//   scl_in    in   raw SCL pin level (asynchronous)
//   sda_in    in   raw SDA pin level (asynchronous)
//   sda_oe    out  1 = pull SDA low
//   wr_data   out  last byte written by the controller
//   wr_valid  out  one-cycle strobe, wr_data is new
//   rd_data   in   next byte to return on a read
//   rd_strobe out  one-cycle strobe, rd_data was loaded
//   busy      out  address matched, transfer in progress
module i2c_target #(
   parameter logic [6:0] ADDR = 7'h42
) (
   input  logic       ref_clk,
   input  logic       rst_n,
   input  logic       scl_in,
   input  logic       sda_in,
   output logic       sda_oe,
   output logic [7:0] wr_data,
   output logic       wr_valid,
   input  logic [7:0] rd_data,
   output logic       rd_strobe,
   output logic       busy
);

   typedef enum logic [2:0] {
      S_IDLE, S_ADDR, S_ADDR_ACK, S_WRITE, S_WRITE_ACK, S_READ, S_READ_ACK, S_IGNORE
   } state_e;

   // 2-flop synchronizers, reset to the idle-bus level
   logic [1:0] scl_sync_q, sda_sync_q;

   always_ff @(posedge ref_clk or negedge rst_n) begin
      if (!rst_n) begin
         scl_sync_q <= 2'b11;
         sda_sync_q <= 2'b11;
      end else begin
         scl_sync_q <= {scl_sync_q[0], scl_in};
         sda_sync_q <= {sda_sync_q[0], sda_in};
      end
   end

   logic scl_l, sda_l;

`ifdef I2C_TARGET_GLITCH_FILTER_EN
   // Filtered level follows the line only after the current sample and the
   // two previous ones agree; spikes of 2 cycles or less never get through.
   logic [1:0] scl_hist_q, sda_hist_q;
   logic       scl_filt_q, sda_filt_q;

   always_ff @(posedge ref_clk or negedge rst_n) begin
      if (!rst_n) begin
         scl_hist_q <= 2'b11;
         sda_hist_q <= 2'b11;
         scl_filt_q <= 1'b1;
         sda_filt_q <= 1'b1;
      end else begin
         scl_hist_q <= {scl_hist_q[0], scl_sync_q[1]};
         sda_hist_q <= {sda_hist_q[0], sda_sync_q[1]};
         if ({scl_hist_q, scl_sync_q[1]} == 3'b111)      scl_filt_q <= 1'b1;
         else if ({scl_hist_q, scl_sync_q[1]} == 3'b000) scl_filt_q <= 1'b0;
         if ({sda_hist_q, sda_sync_q[1]} == 3'b111)      sda_filt_q <= 1'b1;
         else if ({sda_hist_q, sda_sync_q[1]} == 3'b000) sda_filt_q <= 1'b0;
      end
   end

   assign scl_l = scl_filt_q;
   assign sda_l = sda_filt_q;
`else
   assign scl_l = scl_sync_q[1];
   assign sda_l = sda_sync_q[1];
`endif

   // Edge detection on the (filtered) line levels
   logic scl_prev_q, sda_prev_q;

   always_ff @(posedge ref_clk or negedge rst_n) begin
      if (!rst_n) begin
         scl_prev_q <= 1'b1;
         sda_prev_q <= 1'b1;
      end else begin
         scl_prev_q <= scl_l;
         sda_prev_q <= sda_l;
      end
   end

   logic scl_rise_d, scl_fall_d, scl_stable_hi_d, start_d, stop_d;

   assign scl_rise_d      = scl_l & ~scl_prev_q;
   assign scl_fall_d      = ~scl_l & scl_prev_q;
   // SCL must be high in both samples: a simultaneous SCL edge wins over SDA
   assign scl_stable_hi_d = scl_l & scl_prev_q;
   assign start_d         = scl_stable_hi_d & sda_prev_q & ~sda_l;
   assign stop_d          = scl_stable_hi_d & ~sda_prev_q & sda_l;

   state_e     state_q;
   logic [2:0] cnt_q;
   logic [7:0] sh_q;
   logic       rw_q;
   logic       ph_q;      // second phase of an ACK slot
   logic       sda_oe_q, wr_valid_q, rd_strobe_q, busy_q;
   logic [7:0] wr_data_q;

   always_ff @(posedge ref_clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         cnt_q       <= 3'd0;
         sh_q        <= 8'h00;
         rw_q        <= 1'b0;
         ph_q        <= 1'b0;
         sda_oe_q    <= 1'b0;
         wr_valid_q  <= 1'b0;
         rd_strobe_q <= 1'b0;
         busy_q      <= 1'b0;
         wr_data_q   <= 8'h00;
      end else begin
         wr_valid_q  <= 1'b0;
         rd_strobe_q <= 1'b0;
         if (stop_d) begin
            state_q  <= S_IDLE;
            sda_oe_q <= 1'b0;
            busy_q   <= 1'b0;
         end else if (start_d) begin
            state_q  <= S_ADDR;
            cnt_q    <= 3'd0;
            sda_oe_q <= 1'b0;
            busy_q   <= 1'b0;
            ph_q     <= 1'b0;
         end else begin
            case (state_q)
               S_IDLE: ;
               S_ADDR: begin
                  if (scl_rise_d) begin
                     sh_q  <= {sh_q[6:0], sda_l};
                     cnt_q <= cnt_q + 3'd1;
                     if (cnt_q == 3'd7) begin
                        // sh_q[6:0] already holds the 7 address bits; sda_l is R/W
                        if (sh_q[6:0] == ADDR) begin
                           busy_q  <= 1'b1;
                           rw_q    <= sda_l;
                           ph_q    <= 1'b0;
                           state_q <= S_ADDR_ACK;
                        end else begin
                           state_q <= S_IGNORE;
                        end
                     end
                  end
               end
               S_ADDR_ACK: begin
                  if (scl_fall_d) begin
                     if (!ph_q) begin
                        sda_oe_q <= 1'b1;
                        ph_q     <= 1'b1;
                     end else if (!rw_q) begin
                        sda_oe_q <= 1'b0;
                        state_q  <= S_WRITE;
                     end else begin
                        sh_q        <= rd_data;
                        rd_strobe_q <= 1'b1;
                        sda_oe_q    <= ~rd_data[7];
                        state_q     <= S_READ;
                     end
                  end
               end
               S_WRITE: begin
                  if (scl_rise_d) begin
                     sh_q  <= {sh_q[6:0], sda_l};
                     cnt_q <= cnt_q + 3'd1;
                  end else if (scl_fall_d && cnt_q == 3'd0) begin
                     // counter wrapped: a full byte has been shifted in
                     wr_data_q  <= sh_q;
                     wr_valid_q <= 1'b1;
                     sda_oe_q   <= 1'b1;
                     state_q    <= S_WRITE_ACK;
                  end
               end
               S_WRITE_ACK: begin
                  if (scl_fall_d) begin
                     sda_oe_q <= 1'b0;
                     state_q  <= S_WRITE;
                  end
               end
               S_READ: begin
                  if (scl_rise_d) begin
                     cnt_q <= cnt_q + 3'd1;
                  end else if (scl_fall_d) begin
                     if (cnt_q == 3'd0) begin
                        sda_oe_q <= 1'b0;
                        ph_q     <= 1'b0;
                        state_q  <= S_READ_ACK;
                     end else begin
                        sh_q     <= {sh_q[6:0], 1'b0};
                        sda_oe_q <= ~sh_q[6];
                     end
                  end
               end
               S_READ_ACK: begin
                  if (scl_rise_d) begin
                     if (sda_l) begin
                        busy_q  <= 1'b0;
                        state_q <= S_IGNORE;
                     end else begin
                        ph_q <= 1'b1;
                     end
                  end else if (scl_fall_d && ph_q) begin
                     sh_q        <= rd_data;
                     rd_strobe_q <= 1'b1;
                     sda_oe_q    <= ~rd_data[7];
                     ph_q        <= 1'b0;
                     state_q     <= S_READ;
                  end
               end
               S_IGNORE: sda_oe_q <= 1'b0;
               default:  state_q  <= S_IDLE;
            endcase
         end
      end
   end

   assign sda_oe    = sda_oe_q;
   assign wr_data   = wr_data_q;
   assign wr_valid  = wr_valid_q;
   assign rd_strobe = rd_strobe_q;
   assign busy      = busy_q;

endmodule
